// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg: EXE->MEM pipeline register with valid, stall, flush and occupancy; optional PC trace under EXE_MEM_PC_TRACE_EN
module exe_mem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int STAGES = 1,
  parameter int OCC_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DEST_W-1:0] dest,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] pc,
  output logic              valid_out,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic              mem_w_en_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [OCC_W-1:0]  occupancy
);
  localparam int L = STAGES - 1;
  logic [STAGES-1:0] v_q, wb_q, mr_q, mw_q;
  logic [DATA_W-1:0] rm_q [STAGES];
  logic [DEST_W-1:0] dest_q [STAGES];
  logic [DATA_W-1:0] alu_q [STAGES];
  logic [OCC_W-1:0]  occ_q;
  // valid/control slices and occupancy: cleared by rst or flush, held on stall, shifted otherwise
  always_ff @(posedge clk)
    if (rst || flush) begin
      v_q   <= '0;
      wb_q  <= '0;
      mr_q  <= '0;
      mw_q  <= '0;
      occ_q <= '0;
    end else if (!stall) begin
      v_q[0]  <= valid_in;
      wb_q[0] <= wb_en & valid_in;
      mr_q[0] <= mem_r_en & valid_in;
      mw_q[0] <= mem_w_en & valid_in;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]  <= v_q[k-1];
        wb_q[k] <= wb_q[k-1];
        mr_q[k] <= mr_q[k-1];
        mw_q[k] <= mw_q[k-1];
      end
      occ_q <= occ_q + OCC_W'(valid_in) - OCC_W'(v_q[L]);
    end
  // data slices: zeroed by rst, held through stall and flush, captured regardless of valid_in
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        rm_q[k]   <= '0;
        dest_q[k] <= '0;
        alu_q[k]  <= '0;
      end
    end else if (!stall && !flush) begin
      rm_q[0]   <= val_rm;
      dest_q[0] <= dest;
      alu_q[0]  <= alu_res;
      for (int k = 1; k < STAGES; k++) begin
        rm_q[k]   <= rm_q[k-1];
        dest_q[k] <= dest_q[k-1];
        alu_q[k]  <= alu_q[k-1];
      end
    end
`ifdef EXE_MEM_PC_TRACE_EN
  logic [DATA_W-1:0] pc_q [STAGES];
  // pc slices follow the same hold/advance rules as alu_res
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < STAGES; k++) pc_q[k] <= '0;
    end else if (!stall && !flush) begin
      pc_q[0] <= pc;
      for (int k = 1; k < STAGES; k++) pc_q[k] <= pc_q[k-1];
    end
  assign pc_out = pc_q[L];
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign pc_out = '0;
`endif
  assign valid_out    = v_q[L];
  assign wb_en_out    = wb_q[L] & v_q[L];
  assign mem_r_en_out = mr_q[L] & v_q[L];
  assign mem_w_en_out = mw_q[L] & v_q[L];
  assign val_rm_out   = rm_q[L];
  assign dest_out     = dest_q[L];
  assign alu_res_out  = alu_q[L];
  assign occupancy    = occ_q;
endmodule
